// File: rtl/uart_hex_tx.sv
// rtl/uart_hex_tx.sv - formats 16-bit words as ASCII hex text for the UART transmitter
//
// Each accepted word is emitted as four hex digits, most significant nibble
// first, optionally followed by CR LF. One character leaves per output
// handshake.
//
// Parameters:
//   NEWLINE        1: append 0x0D 0x0A after the digits, 0: digits only
//   UPPERCASE      1: digits A-F are 0x41-0x46, 0: they are 0x61-0x66
//
// Ports:
//   clk            in   system clock, rising edge
//   resetn         in   asynchronous active-low reset
//   word_in        in   16-bit word, sampled on the input handshake
//   word_in_valid  in   upstream has a word
//   word_in_ready  out  block can accept a word (decoded from state only)
//   data_out       out  registered ASCII character for uart_tx
//   data_out_valid out  registered, data_out holds a character
//   data_out_ready in   uart_tx accepts the character

module uart_hex_tx #(
    parameter int NEWLINE   = 1,
    parameter int UPPERCASE = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] word_in,
    input  logic        word_in_valid,
    output logic        word_in_ready,
    output logic [7:0]  data_out,
    output logic        data_out_valid,
    input  logic        data_out_ready
);

    // Index of the final character of a string.
    localparam logic [2:0] LAST       = (NEWLINE != 0) ? 3'd5 : 3'd3;
    localparam logic [7:0] ALPHA_BASE = (UPPERCASE != 0) ? 8'h41 : 8'h61;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] word_q, word_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        valid_q, valid_d;

    // 8-bit arithmetic, any carry out is dropped.
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return ALPHA_BASE + {4'h0, n} - 8'd10;
    endfunction

    // Character selected by a string position. Positions 6 and 7 cannot be
    // reached; they decode to '?' so a corrupted index is visible on the wire.
    function automatic logic [7:0] char_at(input logic [15:0] w, input logic [2:0] i);
        case (i)
            3'd0:    return hex_char(w[15:12]);
            3'd1:    return hex_char(w[11:8]);
            3'd2:    return hex_char(w[7:4]);
            3'd3:    return hex_char(w[3:0]);
            3'd4:    return 8'h0D;
            3'd5:    return 8'h0A;
            default: return 8'h3F;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;

        case (state_q)
            IDLE: begin
                if (word_in_valid) begin
                    word_d  = word_in;
                    idx_d   = 3'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (data_out_ready) begin
                    if (idx_q == LAST) begin
                        idx_d   = 3'd0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                idx_d   = 3'd0;
                state_d = IDLE;
            end
        endcase

        // The outputs are registered, so the character for the next cycle is
        // decoded from the next-state values. Under backpressure the next
        // state equals the current one and the character holds.
        valid_d    = (state_d == SEND);
        data_out_d = (state_d == SEND) ? char_at(word_d, idx_d) : 8'h00;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            word_q     <= 16'h0000;
            data_out_q <= 8'h00;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
        end
    end

    assign word_in_ready  = (state_q == IDLE);
    assign data_out       = data_out_q;
    assign data_out_valid = valid_q;

endmodule

// File: tb/tb_uart_hex_tx.sv
// tb/tb_uart_hex_tx.sv - directed self-checking bench for uart_hex_tx

module tb_uart_hex_tx;

    logic        clk;
    logic        resetn;
    logic [15:0] word_in;
    logic        data_out_ready;
    logic        vld0, vld1, vld2;
    logic        rdy0, rdy1, rdy2;
    logic [7:0]  dout0, dout1, dout2;
    logic        dval0, dval1, dval2;

    int checks = 0;
    int errors = 0;
    int sel    = 0;

    logic [7:0] cur_dout;
    logic       cur_dval;
    logic       cur_rdy;

    // Instance 0: CR LF, uppercase. Instance 1: CR LF, lowercase.
    // Instance 2: digits only, uppercase.
    uart_hex_tx #(.NEWLINE(1), .UPPERCASE(1)) u_dut (
        .clk(clk), .resetn(resetn), .word_in(word_in), .word_in_valid(vld0),
        .word_in_ready(rdy0), .data_out(dout0), .data_out_valid(dval0),
        .data_out_ready(data_out_ready)
    );

    uart_hex_tx #(.NEWLINE(1), .UPPERCASE(0)) u_lc (
        .clk(clk), .resetn(resetn), .word_in(word_in), .word_in_valid(vld1),
        .word_in_ready(rdy1), .data_out(dout1), .data_out_valid(dval1),
        .data_out_ready(data_out_ready)
    );

    uart_hex_tx #(.NEWLINE(0), .UPPERCASE(1)) u_nn (
        .clk(clk), .resetn(resetn), .word_in(word_in), .word_in_valid(vld2),
        .word_in_ready(rdy2), .data_out(dout2), .data_out_valid(dval2),
        .data_out_ready(data_out_ready)
    );

    always_comb begin
        cur_dout = dout0;
        cur_dval = dval0;
        cur_rdy  = rdy0;
        case (sel)
            1: begin cur_dout = dout1; cur_dval = dval1; cur_rdy = rdy1; end
            2: begin cur_dout = dout2; cur_dval = dval2; cur_rdy = rdy2; end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Selected instance must show {ready=0, valid=1, exp}; then one edge passes.
    task automatic expect_byte(input string tag, input logic [7:0] exp);
        chk(tag, {6'd0, cur_rdy, cur_dval, cur_dout}, {6'd0, 1'b0, 1'b1, exp});
        step();
    endtask

    // Up to six bytes, first byte in bits 47:40.
    task automatic expect_str(input string tag, input logic [47:0] b, input int n);
        for (int k = 0; k < n; k++) begin
            expect_byte($sformatf("%s[%0d]", tag, k), b[47-8*k -: 8]);
        end
    endtask

    task automatic expect_idle(input string tag);
        chk(tag, {14'd0, cur_rdy, cur_dval}, {14'd0, 2'b10});
    endtask

    task automatic set_valid(input logic v);
        case (sel)
            1:       vld1 = v;
            2:       vld2 = v;
            default: vld0 = v;
        endcase
    endtask

    task automatic accept(input logic [15:0] w);
        word_in = w;
        set_valid(1'b1);
        step();
        set_valid(1'b0);
    endtask

    initial begin
        resetn         = 1'b0;
        word_in        = 16'h0000;
        data_out_ready = 1'b1;
        vld0 = 1'b0; vld1 = 1'b0; vld2 = 1'b0;

        // Reset state
        repeat (2) step();
        chk("reset_dout", {8'd0, dout0}, 16'h0000);
        chk("reset_valid", {15'd0, dval0}, 16'h0000);
        resetn = 1'b1;
        step();
        sel = 0;
        expect_idle("reset_idle");

        // Basic formatting, first byte one cycle after acceptance
        accept(16'h1234);
        expect_str("basic_1234", 48'h31_32_33_34_0D_0A, 6);
        expect_idle("basic_bubble");

        // Letter case
        accept(16'hABCD);
        expect_str("upper_ABCD", 48'h41_42_43_44_0D_0A, 6);
        accept(16'h09F0);
        expect_str("upper_09F0", 48'h30_39_46_30_0D_0A, 6);
        sel = 1;
        accept(16'hABCD);
        expect_str("lower_ABCD", 48'h61_62_63_64_0D_0A, 6);
        expect_idle("lower_bubble");

        // Backpressure after the first byte
        sel = 0;
        accept(16'h1234);
        expect_byte("bp_first", 8'h31);
        data_out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            expect_byte($sformatf("bp_hold%0d", c), 8'h32);
        end
        data_out_ready = 1'b1;
        expect_str("bp_rest", 48'h32_33_34_0D_0A_00, 5);
        expect_idle("bp_bubble");

        // Back-to-back with valid held high, digits only
        sel = 2;
        word_in = 16'h0001;
        vld2    = 1'b1;
        step();
        word_in = 16'hFFFF;
        expect_str("b2b_0001", 48'h30_30_30_31_00_00, 4);
        expect_idle("b2b_bubble");
        step();
        vld2 = 1'b0;
        expect_str("b2b_FFFF", 48'h46_46_46_46_00_00, 4);
        expect_idle("b2b_end");
        step();
        expect_idle("b2b_once");

        // Reset mid-word drops valid without a clock edge
        sel = 0;
        accept(16'h1234);
        expect_str("rst_pre", 48'h31_32_00_00_00_00, 2);
        resetn = 1'b0;
        #1;
        chk("rst_async_valid", {15'd0, dval0}, 16'h0000);
        step();
        resetn = 1'b1;
        step();
        expect_idle("rst_released");
        accept(16'h5678);
        expect_str("rst_5678", 48'h35_36_37_38_0D_0A, 6);

        // Input changes ignored while busy
        word_in = 16'h1234;
        vld0    = 1'b1;
        step();
        word_in = 16'hDEAD;
        expect_str("busy_1234", 48'h31_32_33_34_0D_0A, 6);
        expect_idle("busy_bubble");
        step();
        vld0 = 1'b0;
        expect_str("busy_DEAD", 48'h44_45_41_44_0D_0A, 6);
        expect_idle("busy_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
